// File: rtl/iopmp_rcd_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iopmp_rcd_queue : circular queue of IOPMP violation records with sticky
//                   overflow flag and registered interrupt.
// Optional feature macro: IOPMP_RCD_COALESCE_EN (merge repeats into the tail).
// Revision: 1.0
// ----------------------------------------------------------------------------
module iopmp_rcd_queue #(
  parameter int DEPTH      = 4,
  parameter int SID_WIDTH  = 14,
  parameter int LEN_WIDTH  = 13,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      err_valid_i,
  input  logic [SID_WIDTH-1:0]      err_sid_i,
  input  logic                      err_read_i,
  input  logic [LEN_WIDTH-1:0]      err_len_i,
  input  logic [ADDR_WIDTH-1:0]     err_addr_i,
  input  logic                      pop_i,
  input  logic                      clr_i,
  input  logic                      irq_en_i,
  output logic                      rcd_valid_o,
  output logic [SID_WIDTH-1:0]      rcd_sid_o,
  output logic                      rcd_read_o,
  output logic [LEN_WIDTH-1:0]      rcd_len_o,
  output logic [ADDR_WIDTH-1:0]     rcd_addr_o,
  output logic                      rcd_illcgt_o,
  output logic [3:0]                rcd_rpt_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      irq_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illcgt_q, illcgt_d;
  logic               irq_q, irq_d;

  logic [SID_WIDTH-1:0]  sid_q  [DEPTH];
  logic                  read_q [DEPTH];
  logic [LEN_WIDTH-1:0]  len_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  logic push, do_pop, coal, wr_en, coal_en;

`ifdef IOPMP_RCD_COALESCE_EN
  logic [3:0]        rpt_q [DEPTH];
  logic [PTR_W-1:0]  tail;
  assign tail = wr_ptr_q - PTR_W'(1);
`endif

  always_comb begin
    push   = err_valid_i & enable_i;
    do_pop = pop_i & (state_q != ST_EMPTY);
`ifdef IOPMP_RCD_COALESCE_EN
    // A sole record being retired this cycle cannot absorb a repeat.
    coal = push && (state_q != ST_EMPTY) &&
           (sid_q[tail] == err_sid_i) && (read_q[tail] == err_read_i) &&
           (addr_q[tail] == err_addr_i) &&
           !(do_pop && (count_q == CNT_W'(1)));
`else
    coal = 1'b0;
`endif
    wr_en    = 1'b0;
    coal_en  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    illcgt_d = illcgt_q;

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      illcgt_d = 1'b0;
    end else begin
      coal_en = coal;
      wr_en   = push & ~coal & ((state_q != ST_FULL) | do_pop);
      if (push && !coal && (state_q == ST_FULL) && !do_pop) begin
        illcgt_d = 1'b1;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(do_pop);
    end

    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == C_FULL_CNT) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_ACTIVE;
    end

    irq_d = irq_en_i & ((count_d != '0) | illcgt_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      illcgt_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      illcgt_q <= illcgt_d;
      irq_q    <= irq_d;
    end
  end

  // Record storage is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      sid_q[wr_ptr_q]  <= err_sid_i;
      read_q[wr_ptr_q] <= err_read_i;
      len_q[wr_ptr_q]  <= err_len_i;
      addr_q[wr_ptr_q] <= err_addr_i;
`ifdef IOPMP_RCD_COALESCE_EN
      rpt_q[wr_ptr_q]  <= 4'd0;
`endif
    end
`ifdef IOPMP_RCD_COALESCE_EN
    if (coal_en && (rpt_q[tail] != 4'hF)) begin
      rpt_q[tail] <= rpt_q[tail] + 4'd1;
    end
`endif
  end

  assign rcd_valid_o  = (state_q != ST_EMPTY);
  assign rcd_sid_o    = sid_q[rd_ptr_q];
  assign rcd_read_o   = read_q[rd_ptr_q];
  assign rcd_len_o    = len_q[rd_ptr_q];
  assign rcd_addr_o   = addr_q[rd_ptr_q];
  assign rcd_illcgt_o = illcgt_q;
  assign count_o      = count_q;
  assign irq_o        = irq_q;
`ifdef IOPMP_RCD_COALESCE_EN
  assign rcd_rpt_o    = rcd_valid_o ? rpt_q[rd_ptr_q] : 4'd0;
`else
  assign rcd_rpt_o    = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iopmp_rcd_queue.sv
`default_nettype none
// tb_iopmp_rcd_queue : directed stimulus with a record scoreboard; a monitor
// retires expected records whenever the bench pops a valid head.
module tb_iopmp_rcd_queue;
  localparam int DEPTH = 4;
  localparam int SW    = 14;
  localparam int LW    = 13;
  localparam int AW    = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b1;
  logic          err_valid_i = 1'b0;
  logic [SW-1:0] err_sid_i = '0;
  logic          err_read_i = 1'b0;
  logic [LW-1:0] err_len_i = '0;
  logic [AW-1:0] err_addr_i = '0;
  logic          pop_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          irq_en_i = 1'b1;
  logic          rcd_valid_o;
  logic [SW-1:0] rcd_sid_o;
  logic          rcd_read_o;
  logic [LW-1:0] rcd_len_o;
  logic [AW-1:0] rcd_addr_o;
  logic          rcd_illcgt_o;
  logic [3:0]    rcd_rpt_o;
  logic [2:0]    count_o;
  logic          irq_o;

  iopmp_rcd_queue #(.DEPTH(DEPTH), .SID_WIDTH(SW), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .err_valid_i(err_valid_i), .err_sid_i(err_sid_i), .err_read_i(err_read_i),
    .err_len_i(err_len_i), .err_addr_i(err_addr_i),
    .pop_i(pop_i), .clr_i(clr_i), .irq_en_i(irq_en_i),
    .rcd_valid_o(rcd_valid_o), .rcd_sid_o(rcd_sid_o), .rcd_read_o(rcd_read_o),
    .rcd_len_o(rcd_len_o), .rcd_addr_o(rcd_addr_o),
    .rcd_illcgt_o(rcd_illcgt_o), .rcd_rpt_o(rcd_rpt_o),
    .count_o(count_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [SW-1:0] sid;
    logic          rd;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: a valid head popped this cycle must match the oldest expected record.
  always @(negedge clk_i) begin
    if (rst_ni && pop_i && !clr_i && rcd_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rec_pop: got sid=%h but no record expected", rcd_sid_o);
      end else begin
        rec_t e;
        rec_t a;
        e = exp_q.pop_front();
        a.sid = rcd_sid_o; a.rd = rcd_read_o; a.len = rcd_len_o; a.addr = rcd_addr_o;
        if (a !== e) begin
          bad++;
          $display("FAIL rec_pop: got sid=%h rd=%b len=%h addr=%h want sid=%h rd=%b len=%h addr=%h",
                   a.sid, a.rd, a.len, a.addr, e.sid, e.rd, e.len, e.addr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; keep=1 means the record is expected to be stored.
  task automatic drive(input logic v, input logic [SW-1:0] sid, input logic rd,
                       input logic [AW-1:0] addr, input logic pop, input logic clr,
                       input logic keep);
    rec_t r;
    r.sid = sid; r.rd = rd; r.len = LW'(sid) + LW'(16); r.addr = addr;
    err_valid_i = v; err_sid_i = sid; err_read_i = rd; err_len_i = r.len;
    err_addr_i = addr; pop_i = pop; clr_i = clr;
    if (keep) exp_q.push_back(r);
    cyc();
    err_valid_i = 1'b0; pop_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_valid", 64'(rcd_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_illcgt", 64'(rcd_illcgt_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_rpt", 64'(rcd_rpt_o), 64'd0);
    rst_ni = 1'b1;
    cyc();

    // Single push, 1-cycle visibility
    drive(1'b1, 14'h12, 1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b1);
    chk("push1_valid", 64'(rcd_valid_o), 64'd1);
    chk("push1_sid", 64'(rcd_sid_o), 64'h12);
    chk("push1_count", 64'(count_o), 64'd1);
    chk("push1_irq", 64'(irq_o), 64'd1);
    pop_n(1);
    chk("pop1_count", 64'(count_o), 64'd0);
    chk("pop1_irq", 64'(irq_o), 64'd0);

    // Overflow: 5 pushes, fifth dropped
    for (int i = 1; i <= 5; i++) drive(1'b1, SW'(i), 1'b0, 64'(i * 16), 1'b0, 1'b0, i <= 4);
    chk("ovf_count", 64'(count_o), 64'd4);
    chk("ovf_illcgt", 64'(rcd_illcgt_o), 64'd1);
    chk("ovf_head", 64'(rcd_sid_o), 64'd1);
    pop_n(4);
    chk("ovf_drain_valid", 64'(rcd_valid_o), 64'd0);
    chk("ovf_drain_illcgt", 64'(rcd_illcgt_o), 64'd1);
    chk("ovf_drain_irq", 64'(irq_o), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_illcgt", 64'(rcd_illcgt_o), 64'd0);
    chk("clr_irq", 64'(irq_o), 64'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) drive(1'b1, SW'(i), 1'b1, 64'(i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 14'h9, 1'b0, 64'h900, 1'b1, 1'b0, 1'b1);
    chk("fullpp_count", 64'(count_o), 64'd4);
    chk("fullpp_illcgt", 64'(rcd_illcgt_o), 64'd0);
    chk("fullpp_head", 64'(rcd_sid_o), 64'd2);
    pop_n(3);
    chk("fullpp_last", 64'(rcd_sid_o), 64'd9);
    pop_n(1);
    chk("fullpp_count0", 64'(count_o), 64'd0);

    // Clear beats concurrent push and pop
    for (int i = 6; i <= 8; i++) drive(1'b1, SW'(i), 1'b0, 64'(i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 14'h3F, 1'b0, 64'h3F, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    chk("clrpp_count", 64'(count_o), 64'd0);
    chk("clrpp_illcgt", 64'(rcd_illcgt_o), 64'd0);
    chk("clrpp_irq", 64'(irq_o), 64'd0);
    chk("clrpp_valid", 64'(rcd_valid_o), 64'd0);

    // Empty: pop alone is a no-op, push+pop performs only the push
    pop_n(1);
    chk("empty_pop_count", 64'(count_o), 64'd0);
    drive(1'b1, 14'h2A, 1'b1, 64'hABC, 1'b1, 1'b0, 1'b1);
    chk("empty_pp_count", 64'(count_o), 64'd1);
    chk("empty_pp_sid", 64'(rcd_sid_o), 64'h2A);

    // Active: push+pop leaves count unchanged
    drive(1'b1, 14'h0B, 1'b0, 64'hB0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 14'h0C, 1'b1, 64'hC0, 1'b1, 1'b0, 1'b1);
    chk("active_pp_count", 64'(count_o), 64'd2);
    chk("active_pp_head", 64'(rcd_sid_o), 64'h0B);
    pop_n(2);

    // Disabled: pushes ignored, pop and clear still honoured
    drive(1'b1, 14'h40, 1'b0, 64'h40, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 14'h41, 1'b0, 64'h41, 1'b0, 1'b0, 1'b1);
    enable_i = 1'b0;
    drive(1'b1, 14'h42, 1'b0, 64'h42, 1'b0, 1'b0, 1'b0);
    chk("dis_push_count", 64'(count_o), 64'd2);
    pop_n(1);
    chk("dis_pop_count", 64'(count_o), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    chk("dis_clr_count", 64'(count_o), 64'd0);
    enable_i = 1'b1;

    // Twenty identical pushes
`ifdef IOPMP_RCD_COALESCE_EN
    for (int i = 0; i < 20; i++) drive(1'b1, 14'h3, 1'b1, 64'h100, 1'b0, 1'b0, i == 0);
    chk("rep_count", 64'(count_o), 64'd1);
    chk("rep_rpt", 64'(rcd_rpt_o), 64'd15);
    chk("rep_illcgt", 64'(rcd_illcgt_o), 64'd0);
    pop_n(1);
    chk("rep_rpt_after", 64'(rcd_rpt_o), 64'd0);
`else
    for (int i = 0; i < 20; i++) drive(1'b1, 14'h3, 1'b1, 64'h100, 1'b0, 1'b0, i < 4);
    chk("rep_count", 64'(count_o), 64'd4);
    chk("rep_illcgt", 64'(rcd_illcgt_o), 64'd1);
    chk("rep_rpt", 64'(rcd_rpt_o), 64'd0);
    pop_n(4);
`endif
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with three records held
    for (int i = 0; i < 3; i++) drive(1'b1, SW'(8'h21 + i), 1'b0, 64'(i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 14'h24, 1'b0, 64'h24, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_count", 64'(count_o), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(rcd_valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_illcgt", 64'(rcd_illcgt_o), 64'd0);
    chk("arst_irq", 64'(irq_o), 64'd0);
    chk("arst_rpt", 64'(rcd_rpt_o), 64'd0);
    exp_q.delete();
    cyc();
    rst_ni = 1'b1;
    drive(1'b1, 14'h33, 1'b1, 64'h3300, 1'b0, 1'b0, 1'b1);
    chk("post_rst_head", 64'(rcd_sid_o), 64'h33);
    chk("post_rst_count", 64'(count_o), 64'd1);
    pop_n(1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iopmp_rcd_queue.md
IOPMP_RCD_QUEUE -- requirements
Module: iopmp_rcd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of error records held; power of two, 2..16.
REQ-002 SHALL have parameter SID_WIDTH, default 14, source-ID width.
REQ-003 SHALL have parameter LEN_WIDTH, default 13, transfer-length field width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 64, violating-address width.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable_i, input, 1, IOPMP control enable; errors are captured only when high.
REQ-008 SHALL have ports err_valid_i, err_sid_i, err_read_i and err_len_i (input, 1/SID_WIDTH/1/LEN_WIDTH), a one-cycle violation report.
REQ-009 SHALL have port err_addr_i, input, ADDR_WIDTH, violating address.
REQ-010 SHALL have port pop_i, input, 1, software acknowledge; retires the head record.
REQ-011 SHALL have port clr_i, input, 1, flush all records and the overflow flag.
REQ-012 SHALL have port irq_en_i, input, 1, interrupt enable.
REQ-013 SHALL have ports rcd_valid_o, rcd_sid_o, rcd_read_o, rcd_len_o and rcd_addr_o (output), the head record.
REQ-014 SHALL have port rcd_illcgt_o, output, 1, sticky overflow flag.
REQ-015 SHALL have port rcd_rpt_o, output, 4, head-record repeat count.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1, occupancy.
REQ-017 SHALL have port irq_o, output, 1, registered interrupt.

Function
REQ-018 SHALL implement a circular buffer: write and read pointers of $clog2(DEPTH) bits that wrap DEPTH-1->0, plus an occupancy counter.
REQ-019 SHALL implement FSM states EMPTY (count=0), ACTIVE (0<count<DEPTH) and FULL (count=DEPTH), with next state derived from the updated count.
REQ-020 SHALL define push as err_valid_i AND enable_i; errors are never back-pressured.
REQ-021 SHALL, on a push in EMPTY, make the record visible on rcd_*_o and set rcd_valid_o on the next cycle (1-cycle latency).
REQ-022 SHALL drive rcd_*_o from registered storage at the read pointer; rcd_valid_o=(count!=0).
REQ-023 SHALL treat pop_i in EMPTY as a no-op.
REQ-024 SHALL, on a push in FULL without pop_i, drop the record and set rcd_illcgt_o; the flag stays set until clr_i or reset.
REQ-025 SHALL, on a push and pop_i in the same cycle in FULL, accept both, leave count unchanged and not set the overflow flag.
REQ-026 SHALL, on a push and pop_i in the same cycle in ACTIVE, leave count unchanged; in EMPTY, perform the push only.
REQ-027 SHALL give clr_i priority over push and pop: pointers, count and rcd_illcgt_o go to 0 on the next cycle, and a concurrent push is discarded.
REQ-028 SHALL register irq_o = irq_en_i AND (count!=0 OR rcd_illcgt_o), using next-state values, so irq_o rises in the same cycle rcd_valid_o rises.
REQ-029 SHALL, when enable_i is low, keep held records and still honour pop_i and clr_i.

Reset
REQ-030 SHALL, while rst_ni is low, asynchronously clear pointers, count, overflow flag, irq_o, rcd_valid_o and rcd_rpt_o to 0; record storage is not reset.
REQ-031 SHALL, after rst_ni deasserts mid-operation, discard all prior records and treat the first accepted push as the head.

Configuration
REQ-032 SHALL, with IOPMP_RCD_COALESCE_EN defined, increment a saturating 4-bit repeat field (max 15) on the tail record instead of allocating a new entry when a push has identical sid, read and addr to the tail record and count!=0.
REQ-033 SHALL, with IOPMP_RCD_COALESCE_EN defined, give a new entry a repeat field of 0, and SHALL never set the overflow flag through coalescing.
REQ-034 SHALL, without IOPMP_RCD_COALESCE_EN defined, allocate every push as a new entry and tie rcd_rpt_o to 0.

Verification (DEPTH=4)
REQ-035 SHALL cover: push sid=0x12, addr=0x8000_0000, read=1 -> next cycle rcd_valid_o=1, rcd_sid_o=0x12, count_o=1, irq_o=1 (irq_en_i=1).
REQ-036 SHALL cover: 5 pushes with distinct sids 1..5, no pop -> count_o=4, rcd_illcgt_o=1, head sid=1; after 4 pops rcd_valid_o=0 while rcd_illcgt_o remains 1.
REQ-037 SHALL cover: fill to 4, then push sid=9 with pop_i in the same cycle -> count_o=4, rcd_illcgt_o=0, head sid=2, sid=9 read after 3 more pops.
REQ-038 SHALL cover: 3 pushes, then clr_i with push and pop_i in the same cycle -> count_o=0, rcd_illcgt_o=0, irq_o=0 next cycle.
REQ-039 SHALL cover: COALESCE_EN, 20 identical pushes sid=3, addr=0x100 -> count_o=1, rcd_rpt_o=15; without the macro, count_o=4, rcd_illcgt_o=1.
REQ-040 SHALL cover: rst_ni asserted asynchronously mid-cycle with count=3 -> all outputs 0 immediately; pointers restart at 0 after release.
